// File: rtl/uart_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_frame_ctrl
//  Command-frame parser behind the UART byte receiver.
//  Frame: A5 | CMD | ADDR (MSB first) | LEN | PAYLOAD (write only) | CSUM
//  CSUM is the XOR of CMD through the last payload byte.
//  A valid frame issues one command (cmd_valid/cmd_ready handshake).
//  Writes then stream the buffered payload (wdat_valid/wdat_ready).
//
//  Handshakes: a transfer happens on a rising Sys_clk edge where valid and
//  ready are both high. The valid side holds its data stable until then.
//
// Ports
//  Sys_clk, Rst_n          clock, asynchronous active-low reset
//  rx_data, rx_done        received byte and its one-cycle strobe
//  cmd_valid/ready         command handshake
//  cmd_wr, cmd_addr        1=write / 0=read, big-endian start address
//  cmd_len                 byte count
//  wdat_data/valid/ready   write payload stream
//  busy                    parser not idle
//  err_pulse, err_code     one-cycle error strobe, held code
//                          (0 csum, 1 cmd, 2 len, 3 timeout)
//  rx_drop                 one-cycle: byte discarded during ISSUE/STREAM
// ----------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter int ADDR_BYTES   = 3,
  parameter int PAYLOAD_MAX  = 16,
  parameter int TIMEOUT_CLKS = 50_000
) (
  input  logic                    Sys_clk,
  input  logic                    Rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_wr,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [7:0]              cmd_len,
  output logic [7:0]              wdat_data,
  output logic                    wdat_valid,
  input  logic                    wdat_ready,
  output logic                    busy,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic                    rx_drop
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int BW = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM, S_ISSUE, S_STREAM
  } state_t;

  state_t          state, state_nxt;
  logic            err_set;
  logic [1:0]      err_code_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      ab_cnt;    // address bytes received
  logic [7:0]      rem;       // bytes left in DATA, then in STREAM
  logic [BW-1:0]   idx;       // payload write pointer
  logic [BW-1:0]   k;         // payload read pointer
  logic [7:0]      csum;
  logic            cmd_wr_r;
  logic [AW-1:0]   cmd_addr_r;
  logic [7:0]      cmd_len_r;
  logic [7:0]      pay_mem [PAYLOAD_MAX];
  logic            parsing, tmo_hit, take;

  assign parsing = (state == S_CMD) || (state == S_ADDR) || (state == S_LEN) ||
                   (state == S_DATA) || (state == S_CSUM);
  // A timeout takes priority over a byte landing in the same cycle.
  assign tmo_hit = parsing && (tmo_cnt == TMO_MAX);
  assign take    = rx_done && !tmo_hit;

  assign cmd_valid  = (state == S_ISSUE);
  assign wdat_valid = (state == S_STREAM);
  assign busy       = (state != S_IDLE);
  assign cmd_wr     = cmd_wr_r;
  assign cmd_addr   = cmd_addr_r;
  assign cmd_len    = cmd_len_r;
  assign wdat_data  = (state == S_STREAM) ? pay_mem[k] : 8'h00;

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    if (tmo_hit) begin
      err_set      = 1'b1;
      err_code_nxt = 2'd3;
    end else begin
      case (state)
        S_IDLE:  if (rx_done && rx_data == 8'hA5) state_nxt = S_CMD;
        S_CMD:   if (rx_done) begin
                   if (rx_data == 8'h01 || rx_data == 8'h02) state_nxt = S_ADDR;
                   else begin err_set = 1'b1; err_code_nxt = 2'd1; end
                 end
        S_ADDR:  if (rx_done && ab_cnt == 8'(ADDR_BYTES - 1)) state_nxt = S_LEN;
        S_LEN:   if (rx_done) begin
                   if (rx_data == 8'h00 || (cmd_wr_r && rx_data > 8'(PAYLOAD_MAX))) begin
                     err_set = 1'b1; err_code_nxt = 2'd2;
                   end else state_nxt = cmd_wr_r ? S_DATA : S_CSUM;
                 end
        S_DATA:  if (rx_done && rem == 8'd1) state_nxt = S_CSUM;
        S_CSUM:  if (rx_done) begin
                   if (rx_data == csum) state_nxt = S_ISSUE;
                   else begin err_set = 1'b1; err_code_nxt = 2'd0; end
                 end
        S_ISSUE:  if (cmd_ready) state_nxt = cmd_wr_r ? S_STREAM : S_IDLE;
        S_STREAM: if (wdat_ready && rem == 8'd1) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
    if (err_set) state_nxt = S_IDLE;
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_pulse  <= 1'b0;
      err_code   <= 2'd0;
      rx_drop    <= 1'b0;
      tmo_cnt    <= '0;
      ab_cnt     <= 8'd0;
      rem        <= 8'd0;
      idx        <= '0;
      k          <= '0;
      csum       <= 8'd0;
      cmd_wr_r   <= 1'b0;
      cmd_addr_r <= '0;
      cmd_len_r  <= 8'd0;
    end else begin
      err_pulse <= err_set;
      if (err_set) err_code <= err_code_nxt;
      rx_drop <= rx_done && (state == S_ISSUE || state == S_STREAM);
      tmo_cnt <= (parsing && !rx_done) ? tmo_cnt + TW'(1) : '0;
      if (take) begin
        case (state)
          S_IDLE: if (rx_data == 8'hA5) begin
                    csum   <= 8'd0;
                    idx    <= '0;
                    ab_cnt <= 8'd0;
                  end
          S_CMD:  begin
                    cmd_wr_r <= (rx_data == 8'h01);
                    csum     <= csum ^ rx_data;
                  end
          S_ADDR: begin
                    cmd_addr_r <= (cmd_addr_r << 8) | AW'(rx_data);
                    ab_cnt     <= ab_cnt + 8'd1;
                    csum       <= csum ^ rx_data;
                  end
          S_LEN:  begin
                    cmd_len_r <= rx_data;
                    rem       <= rx_data;
                    csum      <= csum ^ rx_data;
                  end
          S_DATA: begin
                    idx  <= idx + BW'(1);
                    rem  <= rem - 8'd1;
                    csum <= csum ^ rx_data;
                  end
          default: ;
        endcase
      end
      if (state == S_ISSUE && cmd_ready) begin
        rem <= cmd_len_r;
        k   <= '0;
      end
      if (state == S_STREAM && wdat_ready) begin
        rem <= rem - 8'd1;
        k   <= k + BW'(1);
      end
    end
  end

  // Payload storage carries no reset; it is only read while streaming.
  always_ff @(posedge Sys_clk) begin
    if (take && state == S_DATA) pay_mem[idx] <= rx_data;
  end

endmodule
